// File: rtl/match_stat.sv
// Counts rising edges of a match flag over fixed windows of enabled cycles and
// hands each window's count to a ready/valid consumer, flagging dropped results.
module match_stat #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ans,
  input  logic             en,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_data,
  output logic             overrun
);

  localparam int               CYC_W    = $clog2(WINDOW);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [0:0]       ST_EMPTY = 1'b0;
  localparam logic [0:0]       ST_FULL  = 1'b1;

  logic             ans_d_q;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             ovr_q, ovr_d;
  logic             rise;
  logic             close;
  logic [CNT_W-1:0] win_res;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  assign rise    = ans & ~ans_d_q;
  assign close   = en & (cyc_q == CYC_LAST);
  assign win_res = sat_inc(cnt_q, rise);

  always_comb begin
    cyc_d = cyc_q;
    cnt_d = cnt_q;
    if (en) begin
      if (close) begin
        cyc_d = '0;
        cnt_d = '0;
      end else begin
        cyc_d = cyc_q + CYC_W'(1);
        cnt_d = win_res;
      end
    end
  end

  // A close while FULL replaces the result only if the consumer takes the old one now.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    case (state_q)
      ST_EMPTY: begin
        if (close) begin
          state_d = ST_FULL;
          data_d  = win_res;
        end
      end
      default: begin
        if (close) begin
          if (res_ready) data_d = win_res;
          else           ovr_d  = 1'b1;
        end else if (res_ready) begin
          state_d = ST_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans_d_q <= 1'b0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      ans_d_q <= ans;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_data  = data_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_match_stat.sv
// Bench for match_stat: directed scenarios plus random traffic, checked against a
// window-level model of edge counting and the single-slot result buffer.
module tb_match_stat;

  localparam int WINDOW = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ans = 1'b0;
  logic       en = 1'b0;
  logic       res_ready = 1'b0;
  logic       res_valid, overrun, res_valid2, overrun2;
  logic [7:0] res_data;
  logic [1:0] res_data2;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int m_prev, m_pos, m_cnt, m_valid, m_data8, m_data2, m_ovr;

  always #5 clk = ~clk;

  match_stat #(.WINDOW(WINDOW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ans(ans), .en(en), .res_ready(res_ready),
    .res_valid(res_valid), .res_data(res_data), .overrun(overrun)
  );

  match_stat #(.WINDOW(WINDOW), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ans(ans), .en(en), .res_ready(res_ready),
    .res_valid(res_valid2), .res_data(res_data2), .overrun(overrun2)
  );

  task automatic model_reset();
    m_prev = 0; m_pos = 0; m_cnt = 0;
    m_valid = 0; m_data8 = 0; m_data2 = 0; m_ovr = 0;
  endtask

  // Drive one cycle (called at posedge+1), advance the model at the edge, return at posedge+1.
  task automatic step(input logic a, input logic e, input logic r);
    int rise;
    ans = a; en = e; res_ready = r;
    @(posedge clk);
    rise = (a && m_prev == 0) ? 1 : 0;
    m_prev = a ? 1 : 0;
    if (e) begin
      m_cnt += rise;
      if (m_pos == WINDOW - 1) begin
        if (m_valid == 0 || r) begin
          m_valid = 1;
          m_data8 = (m_cnt > 255) ? 255 : m_cnt;
          m_data2 = (m_cnt > 3) ? 3 : m_cnt;
        end else begin
          m_ovr = 1;
        end
        m_cnt = 0;
        m_pos = 0;
      end else begin
        m_pos++;
        if (m_valid != 0 && r) m_valid = 0;
      end
    end else if (m_valid != 0 && r) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ans = 1'b0; en = 1'b0; res_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({res_valid, res_data, overrun, res_valid2, res_data2, overrun2} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_release: got v=%0b d=%0d ov=%0b d2=%0d want all zero",
               res_valid, res_data, overrun, res_data2);
    end
    for (int i = 0; i < 40; i++) step($urandom_range(0, 1) == 1, 1'b1, 1'b0);
    n_tests++;
    if (res_valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_precond: got v=%0b ov=%0b want v=1 ov=1", res_valid, overrun);
    end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({res_valid, res_data, overrun, res_valid2, res_data2, overrun2} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%0b d=%0d ov=%0b d2=%0d want all zero",
               res_valid, res_data, overrun, res_data2);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_pulses();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(i == 2 || i == 5 || i == 9, 1'b1, 1'b1);
      n_tests++;
      if ({res_valid, res_data, res_data2, overrun} !== {m_valid[0], m_data8[7:0], m_data2[1:0], m_ovr[0]}) begin
        n_fail++;
        $display("FAIL pulses c%0d: got v=%0b d=%0d d2=%0d ov=%0b want v=%0d d=%0d d2=%0d ov=%0d",
                 i, res_valid, res_data, res_data2, overrun, m_valid, m_data8, m_data2, m_ovr);
      end
    end
    n_tests++;
    if (res_valid !== 1'b1 || res_data !== 8'd3) begin
      n_fail++;
      $display("FAIL pulses_result: got v=%0b d=%0d want v=1 d=3", res_valid, res_data);
    end
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pulses_consumed: got v=%0b want v=0", res_valid);
    end
  endtask

  task automatic test_held();
    do_reset();
    for (int i = 0; i < 16; i++) step(i >= 3 && i <= 12, 1'b1, 1'b1);
    n_tests++;
    if (res_valid !== 1'b1 || res_data !== 8'd1) begin
      n_fail++;
      $display("FAIL held_single: got v=%0b d=%0d want v=1 d=1", res_valid, res_data);
    end
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(i >= 14 && i <= 18, 1'b1, 1'b1);
      n_tests++;
      if ({res_valid, res_data, res_data2, overrun} !== {m_valid[0], m_data8[7:0], m_data2[1:0], m_ovr[0]}) begin
        n_fail++;
        $display("FAIL held_boundary c%0d: got v=%0b d=%0d d2=%0d ov=%0b want v=%0d d=%0d d2=%0d ov=%0d",
                 i, res_valid, res_data, res_data2, overrun, m_valid, m_data8, m_data2, m_ovr);
      end
      if (i == 15 && (res_valid !== 1'b1 || res_data !== 8'd1)) begin
        n_fail++;
        $display("FAIL held_win1: got v=%0b d=%0d want v=1 d=1", res_valid, res_data);
      end
      if (i == 31 && (res_valid !== 1'b1 || res_data !== 8'd0)) begin
        n_fail++;
        $display("FAIL held_win2: got v=%0b d=%0d want v=1 d=0", res_valid, res_data);
      end
    end
    n_tests += 2;
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(i inside {1, 4, 17, 20, 23, 26}, 1'b1, 1'b0);
      n_tests++;
      if ({res_valid, res_data, res_data2, overrun} !== {m_valid[0], m_data8[7:0], m_data2[1:0], m_ovr[0]}) begin
        n_fail++;
        $display("FAIL overrun c%0d: got v=%0b d=%0d d2=%0d ov=%0b want v=%0d d=%0d d2=%0d ov=%0d",
                 i, res_valid, res_data, res_data2, overrun, m_valid, m_data8, m_data2, m_ovr);
      end
    end
    n_tests++;
    if (res_valid !== 1'b1 || res_data !== 8'd2 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_drop: got v=%0b d=%0d ov=%0b want v=1 d=2 ov=1", res_valid, res_data, overrun);
    end
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (res_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got v=%0b ov=%0b want v=0 ov=1", res_valid, overrun);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 16; i++) step(i inside {1, 3, 5, 7, 15}, 1'b1, 1'b1);
    n_tests++;
    if (res_valid2 !== 1'b1 || res_data2 !== 2'd3 || res_data !== 8'd5) begin
      n_fail++;
      $display("FAIL saturate: got v2=%0b d2=%0d d=%0d want v2=1 d2=3 d=5", res_valid2, res_data2, res_data);
    end
  endtask

  task automatic test_enable();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(i inside {2, 5, 10}, !(i >= 4 && i <= 7), 1'b1);
      n_tests++;
      if ({res_valid, res_data, res_data2, overrun} !== {m_valid[0], m_data8[7:0], m_data2[1:0], m_ovr[0]}) begin
        n_fail++;
        $display("FAIL enable c%0d: got v=%0b d=%0d d2=%0d ov=%0b want v=%0d d=%0d d2=%0d ov=%0d",
                 i, res_valid, res_data, res_data2, overrun, m_valid, m_data8, m_data2, m_ovr);
      end
      if (i == 15 && res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_hold: got v=%0b want v=0", res_valid);
      end
      if (i == 19 && (res_valid !== 1'b1 || res_data !== 8'd2)) begin
        n_fail++;
        $display("FAIL enable_close: got v=%0b d=%0d want v=1 d=2", res_valid, res_data);
      end
    end
    n_tests += 2;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(i inside {0, 20, 24}, 1'b1, i == 31);
      if (i == 15) begin
        n_tests++;
        if (res_valid !== 1'b1 || res_data !== 8'd1) begin
          n_fail++;
          $display("FAIL b2b_first: got v=%0b d=%0d want v=1 d=1", res_valid, res_data);
        end
      end
    end
    n_tests++;
    if (res_valid !== 1'b1 || res_data !== 8'd2 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_reload: got v=%0b d=%0d ov=%0b want v=1 d=2 ov=0", res_valid, res_data, overrun);
    end
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_consumed: got v=%0b want v=0", res_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      step($urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0);
      n_tests++;
      if ({res_valid, res_data, overrun, res_valid2, res_data2, overrun2} !==
          {m_valid[0], m_data8[7:0], m_ovr[0], m_valid[0], m_data2[1:0], m_ovr[0]}) begin
        n_fail++;
        $display("FAIL random c%0d: got v=%0b d=%0d ov=%0b v2=%0b d2=%0d ov2=%0b want v=%0d d=%0d d2=%0d ov=%0d",
                 i, res_valid, res_data, overrun, res_valid2, res_data2, overrun2,
                 m_valid, m_data8, m_data2, m_ovr);
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_pulses();
    test_held();
    test_overrun();
    test_saturate();
    test_enable();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/match_stat.md
MATCH_STAT -- requirements
Module: match_stat

Interface
REQ-001 Parameter WINDOW, default 16, meaning: length of one counting window in enabled clock cycles (>=2).
REQ-002 Parameter CNT_W, default 8, meaning: width of the per-window match count.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ans  input  1  match flag from the upstream sequence detector, sampled every enabled cycle.
REQ-006 en  input  1  count enable; 0 freezes windowing and counting.
REQ-007 res_ready  input  1  consumer accepts res_data when high with res_valid.
REQ-008 res_valid  output  1  res_data holds an unconsumed window result.
REQ-009 res_data  output  CNT_W  number of match events in the completed window.
REQ-010 overrun  output  1  sticky flag: at least one window result was dropped.

Function
REQ-011 Block SHALL register ans into ans_d every cycle regardless of en; a match event is rise = ans & ~ans_d.
REQ-012 Cycle counter cyc (0..WINDOW-1) SHALL increment by 1 on each cycle with en=1 and wrap WINDOW-1 -> 0; en=0 holds cyc.
REQ-013 Window close SHALL occur on an enabled cycle with cyc==WINDOW-1.
REQ-014 Accumulator cnt SHALL add rise on each enabled, non-close cycle, saturating at 2^CNT_W-1 (no wrap).
REQ-015 On window close, window result SHALL be sat(cnt + rise of that cycle) and cnt SHALL clear to 0 on the same edge.
REQ-016 A rise on a cycle with en=0 SHALL be ignored (not counted in any window).
REQ-017 ans held high across many cycles SHALL count as exactly one event; ans high continuing across a window boundary SHALL not recount.
REQ-018 Output control SHALL be a two-state FSM: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-019 EMPTY + close -> FULL, res_data loaded with window result on the close edge (res_valid visible the cycle after close cycle).
REQ-020 FULL + res_ready=1, no close -> EMPTY; res_data holds last value.
REQ-021 FULL + res_ready=1 + close same cycle -> stay FULL, res_data loaded with new result, no overrun.
REQ-022 FULL + res_ready=0 + close -> stay FULL, res_data unchanged, new result dropped, overrun set to 1.
REQ-023 overrun SHALL remain 1 until reset.
REQ-024 res_data and res_valid SHALL not change while FULL and res_ready=0 except per REQ-022 (no change).
REQ-025 Latency: rise on cycle k counted in window containing k; result valid one cycle after that window's close cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force ans_d=0, cyc=0, cnt=0, FSM=EMPTY, res_valid=0, res_data=0, overrun=0.
REQ-027 Reset mid-window SHALL discard the partial count; first window after release starts at cyc=0.
REQ-028 ans=1 on first enabled cycle after release SHALL count as one event (ans_d reset 0).

Verification (WINDOW=16, CNT_W=8 unless stated)
REQ-029 Assert rst_n=0 mid-operation -> res_valid=0, res_data=0, overrun=0 with no clock edge.
REQ-030 en=1, three separate 1-cycle ans pulses in cycles 2,5,9, res_ready=1 -> res_valid=1 for one cycle after cycle 15, res_data=3.
REQ-031 ans held high cycles 3..12 -> res_data=1; ans high cycles 14..18 -> window 1 result 1, window 2 result 0.
REQ-032 res_ready=0 across two closes with 2 then 4 events -> res_data=2, res_valid=1, overrun=1; then res_ready=1 one cycle -> res_valid=0.
REQ-033 CNT_W=2, five events in one window -> res_data=3 (saturated); rise on close cycle (cyc=15) counted in that window.
REQ-034 en=0 for cycles 4..7 with pulses there -> pulses ignored, close delayed by 4 cycles.
